// File: rtl/branch_resolve_unit_pkg.sv
// Shared types for the branch resolve unit: the in-flight entry record and
// the 2-bit PHT counter state encodings.
package branch_resolve_unit_pkg;

  localparam int BRU_PC_WIDTH  = 16;
  localparam int BRU_BHR_WIDTH = 4;

  // 2-bit saturating counter states
  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  // One predicted branch waiting for its outcome.
  // The bhr field width is fixed here; the top's BHR_WIDTH must match it.
  typedef struct packed {
    logic [BRU_PC_WIDTH-1:0]  pc;
    logic                     taken;
    logic [BRU_BHR_WIDTH-1:0] bhr;
    logic [1:0]               ctr;
  } lc3b_bru_entry;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Bus between the fetch/writeback stages and the branch resolve unit.
// Optional statistics outputs are present only when BRU_STATS_EN is defined.
interface branch_resolve_unit_if #(
  parameter int BHR_WIDTH    = 4,
  parameter int PC_IDX_WIDTH = 4
);
  logic                              push;
  logic [15:0]                       push_pc;
  logic                              push_taken;
  logic [BHR_WIDTH-1:0]              push_bhr;
  logic [1:0]                        push_ctr;
  logic                              full;
  logic                              empty;
  logic                              resolve_valid;
  logic                              resolve_taken;
  logic [15:0]                       resolve_target;
  logic                              mispredict;
  logic [15:0]                       redirect_pc;
  logic                              train_valid;
  logic [PC_IDX_WIDTH+BHR_WIDTH-1:0] train_index;
  logic [1:0]                        train_ctr;
  logic                              bhr_restore_valid;
  logic [BHR_WIDTH-1:0]              bhr_restore;
`ifdef BRU_STATS_EN
  logic [15:0]                       stat_branches;
  logic [15:0]                       stat_mispredicts;

  modport master (
    output push, push_pc, push_taken, push_bhr, push_ctr,
    output resolve_valid, resolve_taken, resolve_target,
    input  full, empty, mispredict, redirect_pc, train_valid, train_index,
    input  train_ctr, bhr_restore_valid, bhr_restore,
    input  stat_branches, stat_mispredicts
  );
  modport slave (
    input  push, push_pc, push_taken, push_bhr, push_ctr,
    input  resolve_valid, resolve_taken, resolve_target,
    output full, empty, mispredict, redirect_pc, train_valid, train_index,
    output train_ctr, bhr_restore_valid, bhr_restore,
    output stat_branches, stat_mispredicts
  );
`else
  modport master (
    output push, push_pc, push_taken, push_bhr, push_ctr,
    output resolve_valid, resolve_taken, resolve_target,
    input  full, empty, mispredict, redirect_pc, train_valid, train_index,
    input  train_ctr, bhr_restore_valid, bhr_restore
  );
  modport slave (
    input  push, push_pc, push_taken, push_bhr, push_ctr,
    input  resolve_valid, resolve_taken, resolve_target,
    output full, empty, mispredict, redirect_pc, train_valid, train_index,
    output train_ctr, bhr_restore_valid, bhr_restore
  );
`endif
endinterface

// File: rtl/branch_resolve_unit_bru_ctr_update.sv
// Saturating 2-bit PHT counter next-state. Purely combinational so the
// predictor-side update logic can be compared against it.
module bru_ctr_update
  import branch_resolve_unit_pkg::*;
(
  input  logic [1:0] i_state,
  input  logic       i_taken,
  output logic [1:0] o_next
);

  // Step toward strongly-taken or strongly-not-taken, holding at the ends
  always_comb begin
    o_next = i_state;
    case (i_state)
      SNT:     o_next = i_taken ? WNT : SNT;
      WNT:     o_next = i_taken ? WT  : SNT;
      WT:      o_next = i_taken ? ST  : WNT;
      ST:      o_next = i_taken ? ST  : WT;
      default: o_next = i_state;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: in-order queue of in-flight predictions, compared
// against WB outcomes to produce flush/redirect, PHT training and BHR repair.
// Optional macro BRU_STATS_EN adds saturating resolve/mispredict counters.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int BHR_WIDTH    = BRU_BHR_WIDTH,
  parameter int PC_IDX_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  branch_resolve_unit_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  lc3b_bru_entry     r_queue [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  lc3b_bru_entry     w_head_entry;
  logic              w_full;
  logic              w_empty;
  logic              w_do_resolve;
  logic              w_mispredict;
  logic              w_do_push;
  logic [1:0]        w_next_ctr;

  assign w_head_entry = r_queue[r_head];
  assign w_full       = (r_count == CNT_W'(DEPTH));
  assign w_empty      = (r_count == {CNT_W{1'b0}});
  assign bus.full     = w_full;
  assign bus.empty    = w_empty;

  // A resolve against an empty queue is ignored; a mispredict kills any
  // same-cycle push since it came from the wrong path. A correct pop frees
  // a slot, so a push is accepted even when full.
  assign w_do_resolve = bus.resolve_valid & ~w_empty;
  assign w_mispredict = w_do_resolve & (w_head_entry.taken != bus.resolve_taken);
  assign w_do_push    = bus.push & ~w_mispredict & (~w_full | w_do_resolve);

  bru_ctr_update u_ctr_update (
    .i_state (w_head_entry.ctr),
    .i_taken (bus.resolve_taken),
    .o_next  (w_next_ctr)
  );

  // Entry storage: write the accepted push at the tail
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_queue[i] <= '0;
    end else if (w_do_push) begin
      r_queue[r_tail] <= '{pc: bus.push_pc, taken: bus.push_taken,
                           bhr: bus.push_bhr, ctr: bus.push_ctr};
    end
  end

  // Pointer and occupancy bookkeeping; a mispredict empties the queue
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_head  <= {PTR_W{1'b0}};
      r_tail  <= {PTR_W{1'b0}};
      r_count <= {CNT_W{1'b0}};
    end else if (w_mispredict) begin
      r_head  <= r_head + PTR_W'(1);
      r_tail  <= r_head + PTR_W'(1);
      r_count <= {CNT_W{1'b0}};
    end else begin
      if (w_do_resolve) r_head <= r_head + PTR_W'(1);
      if (w_do_push)    r_tail <= r_tail + PTR_W'(1);
      case ({w_do_push, w_do_resolve})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered resolve outputs: pulses for one cycle, data held otherwise
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus.mispredict        <= 1'b0;
      bus.redirect_pc       <= 16'h0000;
      bus.train_valid       <= 1'b0;
      bus.train_index       <= '0;
      bus.train_ctr         <= 2'b00;
      bus.bhr_restore_valid <= 1'b0;
      bus.bhr_restore       <= '0;
    end else begin
      bus.train_valid       <= w_do_resolve;
      bus.mispredict        <= w_mispredict;
      bus.bhr_restore_valid <= w_mispredict;
      if (w_do_resolve) begin
        bus.train_index <= {w_head_entry.pc[PC_IDX_WIDTH-1:0], w_head_entry.bhr};
        bus.train_ctr   <= w_next_ctr;
      end
      if (w_mispredict) begin
        bus.redirect_pc <= bus.resolve_taken ? bus.resolve_target
                                             : (w_head_entry.pc + 16'd2);
        bus.bhr_restore <= {w_head_entry.bhr[BHR_WIDTH-2:0], bus.resolve_taken};
      end
    end
  end

`ifdef BRU_STATS_EN
  logic [15:0] r_stat_branches;
  logic [15:0] r_stat_mispredicts;

  // Saturating counts of resolved branches and mispredicts
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_stat_branches    <= 16'h0000;
      r_stat_mispredicts <= 16'h0000;
    end else begin
      if (w_do_resolve && (r_stat_branches != 16'hFFFF))
        r_stat_branches <= r_stat_branches + 16'd1;
      if (w_mispredict && (r_stat_mispredicts != 16'hFFFF))
        r_stat_mispredicts <= r_stat_mispredicts + 16'd1;
    end
  end

  assign bus.stat_branches    = r_stat_branches;
  assign bus.stat_mispredicts = r_stat_mispredicts;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios followed by
// randomized traffic, all compared with a queue-based reference model.
module tb_branch_resolve_unit;

  localparam int DEPTH = 4;

  typedef struct {
    logic [15:0] pc;
    logic        taken;
    logic [3:0]  bhr;
    logic [1:0]  ctr;
  } ent_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  ent_t        q[$];
  int          m_branches = 0;
  int          m_mispredicts = 0;

  branch_resolve_unit_if #(.BHR_WIDTH(4), .PC_IDX_WIDTH(4)) bus ();

  branch_resolve_unit #(.DEPTH(DEPTH), .BHR_WIDTH(4), .PC_IDX_WIDTH(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_stats();
`ifdef BRU_STATS_EN
    chk("stat_branches", 32'(bus.stat_branches), 32'(m_branches));
    chk("stat_mispredicts", 32'(bus.stat_mispredicts), 32'(m_mispredicts));
`endif
  endtask

  task automatic idle_inputs();
    bus.push = 1'b0; bus.push_pc = 16'h0000; bus.push_taken = 1'b0;
    bus.push_bhr = 4'h0; bus.push_ctr = 2'b00;
    bus.resolve_valid = 1'b0; bus.resolve_taken = 1'b0; bus.resolve_target = 16'h0000;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    q.delete();
    m_branches = 0;
    m_mispredicts = 0;
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_mispredict", 32'(bus.mispredict), 32'd0);
    chk("rst_train_valid", 32'(bus.train_valid), 32'd0);
    chk("rst_restore_valid", 32'(bus.bhr_restore_valid), 32'd0);
    chk("rst_redirect", 32'(bus.redirect_pc), 32'd0);
    chk("rst_train_index", 32'(bus.train_index), 32'd0);
    chk("rst_train_ctr", 32'(bus.train_ctr), 32'd0);
    chk("rst_restore", 32'(bus.bhr_restore), 32'd0);
    chk_stats();
  endtask

  // One clock of stimulus: drive, predict with the model, clock, compare.
  task automatic step(input logic p, input logic [15:0] ppc, input logic pt,
                      input logic [3:0] pb, input logic [1:0] pcr,
                      input logic rv, input logic rt, input logic [15:0] tgt);
    ent_t        h;
    logic        e_tv, e_mis;
    logic [7:0]  e_idx;
    logic [1:0]  e_ctr;
    logic [15:0] e_red;
    logic [3:0]  e_rest;
    bus.push = p; bus.push_pc = ppc; bus.push_taken = pt;
    bus.push_bhr = pb; bus.push_ctr = pcr;
    bus.resolve_valid = rv; bus.resolve_taken = rt; bus.resolve_target = tgt;
    chk("full_pre", 32'(bus.full), 32'(q.size() == DEPTH));
    chk("empty_pre", 32'(bus.empty), 32'(q.size() == 0));
    e_tv = 1'b0; e_mis = 1'b0; e_idx = 8'h00; e_ctr = 2'b00;
    e_red = 16'h0000; e_rest = 4'h0;
    if (rv && q.size() != 0) begin
      h = q.pop_front();
      e_tv  = 1'b1;
      e_idx = {h.pc[3:0], h.bhr};
      if (rt) e_ctr = (h.ctr == 2'd3) ? 2'd3 : h.ctr + 2'd1;
      else    e_ctr = (h.ctr == 2'd0) ? 2'd0 : h.ctr - 2'd1;
      if (m_branches < 65535) m_branches++;
      if (h.taken != rt) begin
        e_mis  = 1'b1;
        e_red  = rt ? tgt : h.pc + 16'd2;
        e_rest = {h.bhr[2:0], rt};
        q.delete();
        if (m_mispredicts < 65535) m_mispredicts++;
      end
    end
    if (p && !e_mis && q.size() < DEPTH) q.push_back('{ppc, pt, pb, pcr});
    @(posedge clk); #1;
    idle_inputs();
    chk("train_valid", 32'(bus.train_valid), 32'(e_tv));
    chk("mispredict", 32'(bus.mispredict), 32'(e_mis));
    chk("restore_valid", 32'(bus.bhr_restore_valid), 32'(e_mis));
    if (e_tv) begin
      chk("train_index", 32'(bus.train_index), 32'(e_idx));
      chk("train_ctr", 32'(bus.train_ctr), 32'(e_ctr));
    end
    if (e_mis) begin
      chk("redirect_pc", 32'(bus.redirect_pc), 32'(e_red));
      chk("bhr_restore", 32'(bus.bhr_restore), 32'(e_rest));
    end
    chk("empty", 32'(bus.empty), 32'(q.size() == 0));
    chk("full", 32'(bus.full), 32'(q.size() == DEPTH));
    chk_stats();
  endtask

  task automatic push_only(input logic [15:0] ppc, input logic pt,
                           input logic [3:0] pb, input logic [1:0] pcr);
    step(1'b1, ppc, pt, pb, pcr, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic resolve_only(input logic rt, input logic [15:0] tgt);
    step(1'b0, 16'h0000, 1'b0, 4'h0, 2'b00, 1'b1, rt, tgt);
  endtask

  initial begin
    logic        rp, rt;
    idle_inputs();
    do_reset();

    // Correct taken prediction trains the counter upward
    push_only(16'h3000, 1'b1, 4'hA, 2'd2);
    resolve_only(1'b1, 16'h3050);
    chk("tp1_idx", 32'(bus.train_index), 32'h0A);
    chk("tp1_ctr", 32'(bus.train_ctr), 32'd3);
    chk("tp1_mis", 32'(bus.mispredict), 32'd0);
    chk("tp1_empty", 32'(bus.empty), 32'd1);

    // Predicted not-taken, actually taken
    push_only(16'h3004, 1'b0, 4'h3, 2'd1);
    resolve_only(1'b1, 16'h3100);
    chk("tp2_mis", 32'(bus.mispredict), 32'd1);
    chk("tp2_redirect", 32'(bus.redirect_pc), 32'h3100);
    chk("tp2_restore", 32'(bus.bhr_restore), 32'h7);
    chk("tp2_ctr", 32'(bus.train_ctr), 32'd2);

    // Fill to DEPTH, drop the extra push, then drain in order
    for (int i = 0; i < 4; i++) push_only(16'h5000 + 16'(2 * i), 1'b1, 4'(i), 2'd1);
    chk("tp3_full", 32'(bus.full), 32'd1);
    push_only(16'h5100, 1'b1, 4'hF, 2'd1);
    for (int i = 0; i < 4; i++) begin
      resolve_only(1'b1, 16'h6000);
      chk("tp3_order", 32'(bus.train_index), 32'(8'((2 * i) * 16 + i)));
    end
    chk("tp3_drained", 32'(bus.empty), 32'd1);

    // Oldest of three mispredicts not-taken; same-cycle push is wrong-path
    push_only(16'h4000, 1'b1, 4'h1, 2'd2);
    push_only(16'h4010, 1'b1, 4'h2, 2'd2);
    push_only(16'h4020, 1'b1, 4'h3, 2'd2);
    step(1'b1, 16'h4100, 1'b1, 4'h4, 2'd1, 1'b1, 1'b0, 16'h7777);
    chk("tp4_redirect", 32'(bus.redirect_pc), 32'h4002);
    chk("tp4_empty", 32'(bus.empty), 32'd1);
    resolve_only(1'b0, 16'h0000);
    chk("tp4_no_pulse", 32'(bus.train_valid), 32'd0);

    // Counter saturation at both ends
    push_only(16'h2000, 1'b1, 4'h5, 2'd3);
    resolve_only(1'b1, 16'h2222);
    chk("sat_hi", 32'(bus.train_ctr), 32'd3);
    push_only(16'h2002, 1'b0, 4'h6, 2'd0);
    resolve_only(1'b0, 16'h0000);
    chk("sat_lo", 32'(bus.train_ctr), 32'd0);

    // Push with a correct resolve while full keeps the queue full
    for (int i = 0; i < 4; i++) push_only(16'h8000 + 16'(4 * i), 1'b0, 4'(i), 2'd1);
    step(1'b1, 16'h8100, 1'b0, 4'h9, 2'd1, 1'b1, 1'b0, 16'h0000);
    chk("full_swap", 32'(bus.full), 32'd1);

    // Ten resolves, three of them mispredicted, then reset mid-stream
    do_reset();
    for (int i = 0; i < 10; i++) begin
      push_only(16'h1000 + 16'(2 * i), 1'b1, 4'(i), 2'd2);
      resolve_only(i < 3 ? 1'b0 : 1'b1, 16'h1200);
    end
`ifdef BRU_STATS_EN
    chk("stat10", 32'(bus.stat_branches), 32'd10);
    chk("stat3", 32'(bus.stat_mispredicts), 32'd3);
`endif
    push_only(16'h1100, 1'b1, 4'h1, 2'd1);
    push_only(16'h1102, 1'b1, 4'h2, 2'd1);
    do_reset();
    resolve_only(1'b1, 16'h0000);
    chk("post_rst_no_pulse", 32'(bus.train_valid), 32'd0);

    // Randomized traffic, mostly correct predictions
    for (int n = 0; n < 400; n++) begin
      if (n % 150 == 149) do_reset();
      rp = ($urandom_range(0, 9) < 6);
      rt = (q.size() != 0) ? q[0].taken : 1'($urandom);
      if ($urandom_range(0, 4) == 0) rt = ~rt;
      step(rp, 16'($urandom), 1'($urandom), 4'($urandom), 2'($urandom),
           ($urandom_range(0, 9) < 5), rt, 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Resolution-side partner of the global (gshare-style) predictor. Records each prediction made in IF in an in-order in-flight queue, then compares it with the actual outcome when the branch resolves in WB. Produces the mispredict flush/redirect, the PHT training write (index and next 2-bit state), and the corrected BHR value for history repair.

Parameters:
DEPTH, 4, max in-flight predicted branches (power of 2, >=2)
BHR_WIDTH, 4, global history bits
PC_IDX_WIDTH, 4, low PC bits used in the PHT index

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
push  in  1  IF issued a prediction for a branch this cycle
push_pc  in  16  PC of the predicted branch
push_taken  in  1  predicted direction
push_bhr  in  BHR_WIDTH  BHR value used for the prediction index
push_ctr  in  2  PHT counter value read at prediction
full  out  1  queue full; IF must stall branch issue
empty  out  1  no branches in flight
resolve_valid  in  1  WB has the oldest branch's outcome
resolve_taken  in  1  actual direction
resolve_target  in  16  actual taken target
mispredict  out  1  one-cycle pulse: flush younger pipeline state
redirect_pc  out  16  fetch PC valid with mispredict
train_valid  out  1  one-cycle PHT write strobe
train_index  out  PC_IDX_WIDTH+BHR_WIDTH  {pc[PC_IDX_WIDTH-1:0], bhr}
train_ctr  out  2  next counter state
bhr_restore_valid  out  1  pulse with mispredict
bhr_restore  out  BHR_WIDTH  {entry_bhr[BHR_WIDTH-2:0], actual}

Behaviour:
- Reset (reset_n=0 at clk edge): head, tail and count = 0; empty=1, full=0; all pulse outputs 0; redirect_pc, train_index, train_ctr and bhr_restore = 0. Reset mid-operation discards all entries.
- Queue: circular buffer with DEPTH entries {pc, taken, bhr, ctr}. count is $clog2(DEPTH)+1 bits wide. Pointers wrap modulo DEPTH. full = (count==DEPTH); empty = (count==0). Both are combinational from registered state.
- Push while full is dropped. The queue does not change.
- Resolve pops the head in program order. Resolve while empty is ignored: no pops and no pulses.
- Outputs are registered and appear 1 cycle after resolve_valid is sampled:
  - train_valid = 1 on every valid resolve.
  - train_ctr = saturating 2-bit update of the head's ctr: +1 if taken, capped at 3; -1 if not taken, floored at 0.
  - train_index is formed from the head's pc and bhr.
- Mispredict is defined as head.taken != resolve_taken. On a mispredict:
  - mispredict = 1 and bhr_restore_valid = 1.
  - redirect_pc = resolve_target if taken, else head.pc+2 (16-bit wrap).
  - All younger entries are flushed: count becomes 0 and tail is set to head+1.
- Push and resolve in the same cycle:
  - Correct prediction: pop and push both take effect; count is unchanged. Allowed even when full, because the pop frees a slot.
  - Mispredict: the push is wrong-path and is dropped.
- Pulses last exactly one cycle. Back-to-back resolves give back-to-back pulses.

Optional Feature:
- Macro: BRU_STATS_EN.
- When defined, two extra outputs are added:
  - stat_branches (16): resolved-branch count.
  - stat_mispredicts (16): mispredict count.
  - Both saturate at 16'hFFFF and reset to 0.
- When undefined, these ports and counters do not exist. Core behaviour is identical either way.

Decomposition:
- lc3b_types gains:
  - the lc3b_bru_entry struct {pc, taken, bhr, ctr};
  - the 2-bit counter state constants: SNT=0, WNT=1, WT=2, ST=3.
- One sub-module: bru_ctr_update. It is combinational and computes the saturating next-state (state, taken -> next), so the predictor-side pht_update_ctrl logic can be checked against it.

Test Plan:
- Reset, then push pc=0x3000, taken=1, bhr=0xA, ctr=2; resolve taken=1 -> next cycle train_valid=1, train_index=0x0A, train_ctr=3, mispredict=0, empty=1.
- Push pc=0x3004, taken=0, bhr=0x3, ctr=1; resolve taken=1, target=0x3100 -> mispredict=1, redirect_pc=0x3100, bhr_restore=0x7, train_ctr=2.
- Push 4 entries -> full=1; 5th push is dropped. Resolve all 4 correctly -> the 4 train pulses carry the pushed pcs in order.
- Fill 3 entries; oldest mispredicts (predicted taken, actual not taken, pc=0x4000) -> redirect_pc=0x4002, count=0, empty=1. A simultaneous push is dropped.
- Saturation: ctr=3 with taken gives 3; ctr=0 with not-taken gives 0. Resolve when empty gives no pulses.
- With BRU_STATS_EN defined: 10 resolves including 3 mispredicts -> stat_branches=10, stat_mispredicts=3. Assert reset_n mid-stream -> both counters are 0 and the queue is empty.
